uart_reset_sequencer: RTL and testbench

- Reset controller for the Full UART. Synchronizes the board reset internally, stretches it, then releases the UART sub-domains in a fixed order: baud generator, then receiver, then transmitter.
- Also services a software reset request. It first drains an in-flight TX frame, with a timeout, and then replays the same release sequence.
- Sits at top level between the board reset pin and the baud, RX and TX blocks.

---
 rtl/uart_reset_sequencer.sv | 172 +++++++++++++++++
 tb/tb_uart_reset_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reset_sequencer.sv
// Reset sequencer for the Full UART: synchronizes and stretches the board reset, releases baud -> RX -> TX,
// and services drained software resets. Optional watchdog enabled by defining SEQ_WDOG_EN.
module uart_reset_sequencer #(
  parameter int unsigned STRETCH_CYC = 16,
  parameter int unsigned GAP_CYC     = 4,
  parameter int unsigned DRAIN_TO    = 1024,
  parameter int unsigned WD_CYC      = 65536,
  parameter int unsigned CNT_W       = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_rst_req,
  input  logic       tx_busy,
`ifdef SEQ_WDOG_EN
  input  logic       wd_kick,
  output logic       wd_fired,
`endif
  output logic       rst_baud,
  output logic       rst_rx,
  output logic       rst_tx,
  output logic       seq_done,
  output logic       sw_rst_ack,
  output logic       drain_timeout,
  output logic [2:0] seq_state
);

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_STRETCH = 3'd1,
    ST_REL_RX  = 3'd2,
    ST_REL_TX  = 3'd3,
    ST_RUN     = 3'd4,
    ST_DRAIN   = 3'd5,
    ST_ASSERT  = 3'd6
  } state_t;

  localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  if (STRETCH_CYC == 0 || GAP_CYC == 0 || DRAIN_TO == 0 || WD_CYC == 0 ||
      64'(STRETCH_CYC) > CNT_MAX || 64'(GAP_CYC) > CNT_MAX ||
      64'(DRAIN_TO) > CNT_MAX || 64'(WD_CYC) > CNT_MAX) begin : g_bad_params
    $error("uart_reset_sequencer: count parameters must lie in 1 .. 2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] STRETCH_LD = CNT_W'(STRETCH_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD     = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] DRAIN_LD   = CNT_W'(DRAIN_TO - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       sync_q;
  logic             run_trigger;

  assign seq_state = state;

  // Release synchronizer: the async deassertion of rst reaches the FSM two edges later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

`ifdef SEQ_WDOG_EN
  localparam logic [CNT_W-1:0] WD_LD = CNT_W'(WD_CYC - 1);

  logic [CNT_W-1:0] wd_cnt;
  logic             wd_expire;

  assign wd_expire   = (state == ST_RUN) && !wd_kick && (wd_cnt == '0);
  assign run_trigger = sw_rst_req || wd_expire;

  // Held at its load value outside RUN, so RUN entry always starts a full period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt   <= WD_LD;
      wd_fired <= 1'b0;
    end else begin
      if (state != ST_RUN || wd_kick) begin
        wd_cnt <= WD_LD;
      end else if (wd_cnt != '0) begin
        wd_cnt <= wd_cnt - 1'b1;
      end
      if (wd_expire) begin
        wd_fired <= 1'b1;
      end
    end
  end
`else
  assign run_trigger = sw_rst_req;
`endif

  // Request/ack contract: sw_rst_req is a level sampled only in RUN (never queued); sw_rst_ack is a
  // single-cycle pulse on the edge the domain resets are re-applied, whether the drain was clean or not.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_HOLD;
      cnt           <= '0;
      rst_baud      <= 1'b1;
      rst_rx        <= 1'b1;
      rst_tx        <= 1'b1;
      seq_done      <= 1'b0;
      sw_rst_ack    <= 1'b0;
      drain_timeout <= 1'b0;
    end else begin
      sw_rst_ack <= 1'b0;
      case (state)
        ST_HOLD: begin
          if (sync_q[1]) begin
            state <= ST_STRETCH;
            cnt   <= STRETCH_LD;
          end
        end
        ST_STRETCH, ST_ASSERT: begin
          if (cnt == '0) begin
            rst_baud <= 1'b0;
            state    <= ST_REL_RX;
            cnt      <= GAP_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_REL_RX: begin
          if (cnt == '0) begin
            rst_rx <= 1'b0;
            state  <= ST_REL_TX;
            cnt    <= GAP_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_REL_TX: begin
          if (cnt == '0) begin
            rst_tx   <= 1'b0;
            seq_done <= 1'b1;
            state    <= ST_RUN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RUN: begin
          if (run_trigger) begin
            state <= ST_DRAIN;
            cnt   <= DRAIN_LD;
          end
        end
        ST_DRAIN: begin
          // tx_busy low wins over expiry on the same edge: that is a clean drain.
          if (!tx_busy || cnt == '0) begin
            if (tx_busy) begin
              drain_timeout <= 1'b1;
            end
            rst_baud   <= 1'b1;
            rst_rx     <= 1'b1;
            rst_tx     <= 1'b1;
            seq_done   <= 1'b0;
            sw_rst_ack <= 1'b1;
            state      <= ST_ASSERT;
            cnt        <= STRETCH_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= ST_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reset_sequencer.sv
// Bench for uart_reset_sequencer: expected waveforms derived from elapsed-edge arithmetic.
// Defining SEQ_WDOG_EN also exercises the watchdog.
module tb_uart_reset_sequencer;

  localparam int S       = 16;
  localparam int G       = 4;
  localparam int D_A     = 1024;
  localparam int D_B     = 8;
  localparam int WD      = 32;
  localparam int SEQ_LEN = S + 2 * G;

  logic clk        = 1'b0;
  logic rst        = 1'b1;
  logic sw_rst_req = 1'b0;
  logic tx_busy    = 1'b0;
  logic sel        = 1'b0;
  logic wd_kick    = 1'b1;

  logic a_baud, a_rx, a_tx, a_done, a_ack, a_dt;
  logic b_baud, b_rx, b_tx, b_done, b_ack, b_dt;
  logic [2:0] a_state, b_state;
  logic o_baud, o_rx, o_tx, o_done, o_ack, o_dt;
`ifdef SEQ_WDOG_EN
  logic a_wd, b_wd, o_wd;
`endif

  int tests  = 0;
  int errors = 0;
  logic exp_dt = 1'b0;
  logic exp_wd = 1'b0;
  logic [5:0] exp_q[$];

  always #5 clk = ~clk;

  uart_reset_sequencer #(.WD_CYC(WD)) dut_a (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req), .tx_busy(tx_busy),
`ifdef SEQ_WDOG_EN
    .wd_kick(wd_kick), .wd_fired(a_wd),
`endif
    .rst_baud(a_baud), .rst_rx(a_rx), .rst_tx(a_tx), .seq_done(a_done),
    .sw_rst_ack(a_ack), .drain_timeout(a_dt), .seq_state(a_state)
  );

  uart_reset_sequencer #(.DRAIN_TO(D_B), .WD_CYC(WD)) dut_b (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req), .tx_busy(tx_busy),
`ifdef SEQ_WDOG_EN
    .wd_kick(wd_kick), .wd_fired(b_wd),
`endif
    .rst_baud(b_baud), .rst_rx(b_rx), .rst_tx(b_tx), .seq_done(b_done),
    .sw_rst_ack(b_ack), .drain_timeout(b_dt), .seq_state(b_state)
  );

  assign o_baud = sel ? b_baud : a_baud;
  assign o_rx   = sel ? b_rx   : a_rx;
  assign o_tx   = sel ? b_tx   : a_tx;
  assign o_done = sel ? b_done : a_done;
  assign o_ack  = sel ? b_ack  : a_ack;
  assign o_dt   = sel ? b_dt   : a_dt;
`ifdef SEQ_WDOG_EN
  assign o_wd   = sel ? b_wd   : a_wd;
`endif

  // {rst_baud, rst_rx, rst_tx, seq_done} k edges after the stretch count starts (k<0: still held).
  function automatic logic [3:0] seq_vec(input int k);
    seq_vec = {k < S, k < S + G, k < SEQ_LEN, k >= SEQ_LEN};
  endfunction

  task automatic test_power_on(input bit noisy);
    logic [5:0] obs, exp;
    #($urandom_range(1, 3));
    rst = 1'b0; sw_rst_req = 1'b0; tx_busy = 1'b0;
    #1;
    exp_dt = 1'b0; exp_wd = 1'b0;
    obs = {o_baud, o_rx, o_tx, o_done, o_ack, o_dt};
    tests++;
    if (obs !== 6'b111000) begin
      errors++; $display("FAIL async_reset: got %b expected %b", obs, 6'b111000);
    end
`ifdef SEQ_WDOG_EN
    tests++;
    if (o_wd !== 1'b0) begin
      errors++; $display("FAIL async_reset_wd: got %b expected 0", o_wd);
    end
`endif
    repeat (5) @(negedge clk);
    rst = 1'b1;
    for (int n = 1; n <= SEQ_LEN + 6; n++) begin
      if (noisy && n <= SEQ_LEN + 3) begin
        sw_rst_req = 1'($urandom_range(0, 1));
        tx_busy    = 1'($urandom_range(0, 1));
      end else begin
        sw_rst_req = 1'b0;
        tx_busy    = 1'b0;
      end
      @(negedge clk);
      exp = {seq_vec(n - 3), 1'b0, 1'b0};
      obs = {o_baud, o_rx, o_tx, o_done, o_ack, o_dt};
      tests++;
      if (obs !== exp) begin
        errors++; $display("FAIL power_on edge %0d: got %b expected %b", n, obs, exp);
      end
      tests++;
      if ((o_baud && !o_rx) || (o_rx && !o_tx)) begin
        errors++; $display("FAIL power_on_order edge %0d: got baud/rx/tx %b%b%b", n, o_baud, o_rx, o_tx);
      end
    end
    sw_rst_req = 1'b0; tx_busy = 1'b0;
  endtask

  // Starts in RUN; tx_busy stays high for the first b drain edges.
  task automatic soft_reset_scenario(input int b);
    logic [5:0] obs, exp;
    int d, xe, n;
    d  = sel ? D_B : D_A;
    xe = (b + 1 < d) ? b + 1 : d;
    exp_q.delete();
    for (int j = 0; j < xe; j++) exp_q.push_back({4'b0001, 1'b0, exp_dt});
    if (b >= d) exp_dt = 1'b1;
    exp_q.push_back({4'b1110, 1'b1, exp_dt});
    for (int k = 1; k <= SEQ_LEN + 1; k++) exp_q.push_back({seq_vec(k), 1'b0, exp_dt});
    n = 0;
    while (exp_q.size() > 0) begin
      if (n == 0) sw_rst_req = 1'b1;
      else if (n <= xe + SEQ_LEN) sw_rst_req = 1'($urandom_range(0, 1));
      else sw_rst_req = 1'b0;
      if (n >= 1 && n <= xe) tx_busy = (n <= b);
      else tx_busy = 1'($urandom_range(0, 1));
      @(negedge clk);
      exp = exp_q.pop_front();
      obs = {o_baud, o_rx, o_tx, o_done, o_ack, o_dt};
      tests++;
      if (obs !== exp) begin
        errors++; $display("FAIL soft_reset b=%0d edge %0d: got %b expected %b", b, n, obs, exp);
      end
      tests++;
      if ((o_baud && !o_rx) || (o_rx && !o_tx)) begin
        errors++; $display("FAIL soft_order b=%0d edge %0d: got baud/rx/tx %b%b%b", b, n, o_baud, o_rx, o_tx);
      end
      n++;
    end
    sw_rst_req = 1'b0; tx_busy = 1'b0;
  endtask

  task automatic test_reset;
    test_power_on(1'b0);
    test_power_on(1'b1);
  endtask

  task automatic test_soft_clean;
    logic [5:0] obs;
    int idle;
    for (int r = 0; r < 4; r++) begin
      idle = $urandom_range(0, 5);
      for (int i = 0; i < idle; i++) begin
        tx_busy = 1'($urandom_range(0, 1));
        @(negedge clk);
        obs = {o_baud, o_rx, o_tx, o_done, o_ack, o_dt};
        tests++;
        if (obs !== {5'b00010, exp_dt}) begin
          errors++; $display("FAIL run_idle: got %b expected %b", obs, {5'b00010, exp_dt});
        end
      end
      tx_busy = 1'b0;
      soft_reset_scenario(0);
    end
  endtask

  task automatic test_drain_busy;
    soft_reset_scenario(300);
    soft_reset_scenario($urandom_range(1, 100));
    soft_reset_scenario($urandom_range(1, 100));
  endtask

  task automatic test_req_held;
    logic [5:0] obs, exp;
    int total, idx;
    exp_q.delete();
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back({4'b0001, 1'b0, exp_dt});
      exp_q.push_back({4'b1110, 1'b1, exp_dt});
      for (int k = 1; k <= SEQ_LEN; k++) exp_q.push_back({seq_vec(k), 1'b0, exp_dt});
    end
    exp_q.push_back({4'b0001, 1'b0, exp_dt});
    total = exp_q.size();
    idx = 0;
    tx_busy = 1'b0;
    while (exp_q.size() > 0) begin
      sw_rst_req = (idx < total - 1);
      @(negedge clk);
      exp = exp_q.pop_front();
      obs = {o_baud, o_rx, o_tx, o_done, o_ack, o_dt};
      tests++;
      if (obs !== exp) begin
        errors++; $display("FAIL req_held edge %0d: got %b expected %b", idx, obs, exp);
      end
      idx++;
    end
    sw_rst_req = 1'b0;
  endtask

  task automatic test_drain_timeout;
    sel = 1'b1;
    test_power_on(1'b0);
    soft_reset_scenario(D_B - 1);
    soft_reset_scenario(D_B + $urandom_range(0, 40));
    soft_reset_scenario(0);
    soft_reset_scenario($urandom_range(1, D_B - 2));
    test_power_on(1'b0);
    sel = 1'b0;
    test_power_on(1'b0);
  endtask

  task automatic test_rst_midway;
    logic [5:0] obs, exp;
    int stop;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    stop = $urandom_range(S + 3, S + 2 + G);
    for (int n = 1; n <= stop; n++) begin
      @(negedge clk);
      exp = {seq_vec(n - 3), 2'b00};
      obs = {o_baud, o_rx, o_tx, o_done, o_ack, o_dt};
      tests++;
      if (obs !== exp) begin
        errors++; $display("FAIL pre_interrupt edge %0d: got %b expected %b", n, obs, exp);
      end
    end
    test_power_on(1'b0);
    sw_rst_req = 1'b1; tx_busy = 1'b1;
    @(negedge clk);
    sw_rst_req = 1'b0;
    stop = $urandom_range(1, 200);
    for (int j = 1; j <= stop; j++) begin
      @(negedge clk);
      obs = {o_baud, o_rx, o_tx, o_done, o_ack, o_dt};
      tests++;
      if (obs !== 6'b000100) begin
        errors++; $display("FAIL drain_hold edge %0d: got %b expected %b", j, obs, 6'b000100);
      end
    end
    test_power_on(1'b1);
  endtask

`ifdef SEQ_WDOG_EN
  task automatic test_watchdog;
    logic [6:0] obs, exp;
    sw_rst_req = 1'b0; tx_busy = 1'b0;
    for (int p = 0; p < 3; p++) begin
      for (int i = 1; i <= 20; i++) begin
        wd_kick = (i == 20);
        @(negedge clk);
        obs = {o_baud, o_rx, o_tx, o_done, o_ack, o_dt, o_wd};
        exp = {5'b00010, exp_dt, 1'b0};
        tests++;
        if (obs !== exp) begin
          errors++; $display("FAIL wd_kicked p=%0d i=%0d: got %b expected %b", p, i, obs, exp);
        end
      end
    end
    wd_kick = 1'b0;
    for (int i = 1; i <= WD; i++) begin
      @(negedge clk);
      if (i == WD) exp_wd = 1'b1;
      obs = {o_baud, o_rx, o_tx, o_done, o_ack, o_dt, o_wd};
      exp = {5'b00010, exp_dt, exp_wd};
      tests++;
      if (obs !== exp) begin
        errors++; $display("FAIL wd_countdown i=%0d: got %b expected %b", i, obs, exp);
      end
    end
    wd_kick = 1'b1;
    for (int k = 0; k <= SEQ_LEN + 1; k++) begin
      @(negedge clk);
      obs = {o_baud, o_rx, o_tx, o_done, o_ack, o_dt, o_wd};
      exp = {seq_vec(k), k == 0, exp_dt, 1'b1};
      tests++;
      if (obs !== exp) begin
        errors++; $display("FAIL wd_soft_seq k=%0d: got %b expected %b", k, obs, exp);
      end
    end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    #1;
    test_reset();
    test_soft_clean();
    test_drain_busy();
    test_req_held();
    test_drain_timeout();
    test_rst_midway();
`ifdef SEQ_WDOG_EN
    test_watchdog();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
